// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM encoding and helpers for the sequenced ALU.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd8;
    localparam logic [OP_W-1:0] OP_MULLO = 4'd9;
    localparam logic [OP_W-1:0] OP_MULHI = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MULLO) || (op == OP_MULHI);
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one step per cycle, WIDTH steps after start.
// done flags the final step; product then carries the value that step produces.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     cnt_q;
    logic               run_q;

    // Low half of acc holds the remaining multiplier bits; high half accumulates.
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign step    = {sum, acc_q[WIDTH-1:1]};
    assign done    = run_q && (cnt_q == LAST);
    assign product = step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            acc_q <= step;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and an iterative multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             msb,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             c_q, msb_q, zero_q, ovf_q, mulhi_q;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_ext, sub_ext, sll_ext, srl_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0] alu_res, res_n;
    logic             alu_c, alu_v, c_n, v_n;
    logic             load, mul_start, mul_done;
    logic [2*WIDTH-1:0] prod;

    assign amt     = b[SHW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Extra bit beside each shift catches the last bit shifted out (0 when amt is 0).
    assign sll_ext = {1'b0, a} << amt;
    assign srl_ext = {a, 1'b0} >> amt;
    assign sra_ext = $signed({a, 1'b0}) >>> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SLL: begin
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_ext[WIDTH:1];
                alu_c   = srl_ext[0];
            end
            OP_SRA: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            default: ;
        endcase
    end

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (prod)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        mul_start = 1'b0;
        res_n     = alu_res;
        c_n       = alu_c;
        v_n       = alu_v;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(op)) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    load    = 1'b1;
                    res_n   = mulhi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                    c_n     = mulhi_q ? 1'b0 : |prod[2*WIDTH-1:WIDTH];
                    v_n     = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            msb_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mulhi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mulhi_q <= (op == OP_MULHI);
            end
            if (load) begin
                result_q <= res_n;
                c_q      <= c_n;
                msb_q    <= res_n[WIDTH-1];
                zero_q   <= (res_n == '0);
                ovf_q    <= v_n;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL);
    assign result    = result_q;
    assign c_out     = c_q;
    assign msb       = msb_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    op;
    logic [W-1:0]  a, b, result;
    logic          c_out, msb, zero, ovf, busy;

    int errors = 0;
    int checks = 0;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .msb       (msb),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result/carry/overflow straight from the operation definitions.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic c, output logic v);
        longint s;
        logic [63:0] p;
        int amt;
        amt = int'(y[4:0]);
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            4'd0: begin
                p = {32'd0, x} + {32'd0, y};
                r = p[31:0];
                c = p[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = x - y;
                c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x;
            4'd6: begin
                r = x << amt;
                c = (amt == 0) ? 1'b0 : x[32-amt];
            end
            4'd7: begin
                r = x >> amt;
                c = (amt == 0) ? 1'b0 : x[amt-1];
            end
            4'd8: begin
                r = $signed(x) >>> amt;
                c = (amt == 0) ? 1'b0 : x[amt-1];
            end
            4'd9: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0];
                c = |p[63:32];
            end
            4'd10: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[63:32];
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold);
        logic [W-1:0] er;
        logic ec, ev;
        bit is_mul, hs_bad, st_bad;
        int n;
        model(o, x, y, er, ec, ev);
        is_mul = (o == 4'd9) || (o == 4'd10);
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the captured operands must be used.
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'($urandom);
        n = 0;
        hs_bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (out_valid !== 1'b1 && (in_ready !== 1'b0 || busy !== is_mul)) hs_bad = 1;
        end while (out_valid !== 1'b1 && n < 100);
        chk($sformatf("latency op%0d", o), 64'(n), is_mul ? 64'd33 : 64'd1);
        chk("busy_in_ready_wait", 64'(hs_bad), 64'd0);
        chk($sformatf("result op%0d", o), 64'(result), 64'(er));
        chk($sformatf("c_out op%0d", o), 64'(c_out), 64'(ec));
        chk($sformatf("ovf op%0d", o), 64'(ovf), 64'(ev));
        chk("zero", 64'(zero), 64'(er == 0));
        chk("msb", 64'(msb), 64'(er[W-1]));
        chk("done_busy_ready", {62'd0, busy, in_ready}, 64'd0);
        st_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (result !== er || c_out !== ec || ovf !== ev || zero !== (er == 0) ||
                out_valid !== 1'b1 || in_ready !== 1'b0) st_bad = 1;
        end
        if (hold > 0) chk("hold_stable", 64'(st_bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [3:0] ro;
        logic [W-1:0] rx, ry;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", {59'd0, c_out, msb, zero, ovf, busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd0, 32'd5, 32'd6, 0);
        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'd1, 32'd1245, 32'd1245, 0);
        run_op(4'd1, 32'd5, 32'd6, 0);
        run_op(4'd6, 32'd5, 32'd2, 0);
        run_op(4'd8, 32'h8000_0001, 32'd1, 0);
        run_op(4'd7, 32'h8000_0000, 32'd31, 0);
        run_op(4'd7, 32'h1234_5678, 32'd0, 0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(4'd13, 32'hDEAD_BEEF, 32'h1, 0);
        run_op(4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5);

        // Reset in the middle of a multiply abandons it.
        op = 4'd9;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_mul_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        run_op(4'd0, 32'd1245, 32'd7836, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = $urandom;
            if (i % 5 == 0) rx = 32'h8000_0000 | (rx & 32'hF);
            if (i % 7 == 0) ry = rx;
            run_op(ro, rx, ry, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
